// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared definitions for the memory-access pipeline stage.
//               - one-hot load-type bit indices
//               - field positions inside the 81-bit exception/CSR bundle
//                 {csr_we, csr_wmask, csr_wvalue, csr_num, syscall, ertn}
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Bit positions in the one-hot load-type vector.
    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;
    localparam int LD_W_ONEHOT = 5;

    // Exception/CSR bundle layout, LSB first.
    localparam int EX_ERTN         = 0;
    localparam int EX_SYSCALL      = 1;
    localparam int EX_CSR_NUM_LO   = 2;
    localparam int EX_CSR_NUM_HI   = 15;
    localparam int EX_CSR_WVAL_LO  = 16;
    localparam int EX_CSR_WVAL_HI  = 47;
    localparam int EX_CSR_WMASK_LO = 48;
    localparam int EX_CSR_WMASK_HI = 79;
    localparam int EX_CSR_WE       = 80;
    localparam int EX_ZIP_W        = 81;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load-data extraction. Selects the byte or
//               halfword addressed by addr from a 32-bit word and sign- or
//               zero-extends it according to the one-hot load type.
//               Alignment is not checked.
// Ports       : data    [31:0] raw word read from memory
//               addr    [1:0]  low address bits
//               ld_inst [4:0]  one-hot {ld.hu, ld.bu, ld.w, ld.h, ld.b}
//               result  [31:0] extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [LD_W_ONEHOT-1:0] ld_inst,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = data[7:0];
        case (addr)
            2'd0:    w_byte = data[7:0];
            2'd1:    w_byte = data[15:8];
            2'd2:    w_byte = data[23:16];
            default: w_byte = data[31:24];
        endcase
    end

    assign w_half = addr[1] ? data[31:16] : data[15:0];

    // With no type bit set the raw word passes through, same as ld.w.
    always_comb begin
        result = data;
        if (ld_inst[LD_B]) begin
            result = {{24{w_byte[7]}}, w_byte};
        end else if (ld_inst[LD_BU]) begin
            result = {24'd0, w_byte};
        end else if (ld_inst[LD_H]) begin
            result = {{16{w_half[15]}}, w_half};
        end else if (ld_inst[LD_HU]) begin
            result = {16'd0, w_half};
        end else if (ld_inst[LD_W]) begin
            result = data;
        end
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the five-stage LoongArch pipeline.
//               Registers the instruction handed over by execute, captures
//               the data SRAM read word on the first cycle of a load so that
//               a writeback stall cannot lose it, extends sub-word loads and
//               forwards the result plus CSR/exception bundle to writeback.
// Ports       : clk, resetn (sync, active-low)
//               es_*            instruction payload from execute
//               data_sram_rdata read word, valid one cycle after request
//               ws_allowin      writeback handshake
//               wb_ex           flush from writeback (exception/ertn)
//               ms_*            payload to writeback and hazard status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   es_to_ms_valid,
    output logic                   ms_allowin,
    input  logic [31:0]            es_pc,
    input  logic                   es_rf_we,
    input  logic [4:0]             es_rf_waddr,
    input  logic [31:0]            es_alu_result,
    input  logic                   es_res_from_mem,
    input  logic [LD_W_ONEHOT-1:0] es_ld_inst,
    input  logic                   es_csr_re,
    input  logic [EX_ZIP_W-1:0]    es_ex_zip,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allowin,
    input  logic                   wb_ex,
    output logic                   ms_to_ws_valid,
    output logic [31:0]            ms_pc,
    output logic                   ms_rf_we,
    output logic [4:0]             ms_rf_waddr,
    output logic [31:0]            ms_final_result,
    output logic                   ms_res_from_mem,
    output logic                   ms_csr_re,
    output logic [EX_ZIP_W-1:0]    ms_ex_zip,
    output logic                   ms_ex
);

    logic                   r_valid;
    logic [31:0]            r_pc;
    logic                   r_rf_we;
    logic [4:0]             r_rf_waddr;
    logic [31:0]            r_alu_result;
    logic                   r_res_from_mem;
    logic [LD_W_ONEHOT-1:0] r_ld_inst;
    logic                   r_csr_re;
    logic [EX_ZIP_W-1:0]    r_ex_zip;
    logic [31:0]            r_rdata_buf;
    logic                   r_rdata_vld;

    logic                   w_ready_go;
    logic                   w_accept;
    logic [31:0]            w_rdata;
    logic [31:0]            w_load_result;

    assign w_ready_go = 1'b1;
    assign ms_allowin = !r_valid || (w_ready_go && ws_allowin);
    assign w_accept   = es_to_ms_valid && ms_allowin;

    // Stage valid: flush beats everything, including a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (wb_ex) begin
            r_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_valid <= es_to_ms_valid;
        end
    end

    // Payload may load during a flush; r_valid masks it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc           <= 32'd0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= 5'd0;
            r_alu_result   <= 32'd0;
            r_res_from_mem <= 1'b0;
            r_ld_inst      <= '0;
            r_csr_re       <= 1'b0;
            r_ex_zip       <= '0;
        end else if (w_accept) begin
            r_pc           <= es_pc;
            r_rf_we        <= es_rf_we;
            r_rf_waddr     <= es_rf_waddr;
            r_alu_result   <= es_alu_result;
            r_res_from_mem <= es_res_from_mem;
            r_ld_inst      <= es_ld_inst;
            r_csr_re       <= es_csr_re;
            r_ex_zip       <= es_ex_zip;
        end
    end

    // The SRAM output is only guaranteed during the first cycle after the
    // request; snapshot it then so a writeback stall sees stable data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata_buf <= 32'd0;
            r_rdata_vld <= 1'b0;
        end else if (wb_ex || w_accept) begin
            r_rdata_vld <= 1'b0;
        end else if (r_valid && r_res_from_mem && !r_rdata_vld) begin
            r_rdata_buf <= data_sram_rdata;
            r_rdata_vld <= 1'b1;
        end
    end

    assign w_rdata = r_rdata_vld ? r_rdata_buf : data_sram_rdata;

    load_extend u_load_extend (
        .data    (w_rdata),
        .addr    (r_alu_result[1:0]),
        .ld_inst (r_ld_inst),
        .result  (w_load_result)
    );

    assign ms_to_ws_valid  = r_valid && w_ready_go;
    assign ms_pc           = r_pc;
    assign ms_rf_we        = r_valid && r_rf_we;
    assign ms_rf_waddr     = r_rf_waddr;
    assign ms_final_result = r_res_from_mem ? w_load_result : r_alu_result;
    assign ms_res_from_mem = r_valid && r_res_from_mem;
    assign ms_csr_re       = r_csr_re;
    assign ms_ex_zip       = r_ex_zip;
    assign ms_ex           = r_valid && (r_ex_zip[EX_SYSCALL] || r_ex_zip[EX_ERTN]);

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_alu_result;
    logic        es_res_from_mem;
    logic [4:0]  es_ld_inst;
    logic        es_csr_re;
    logic [80:0] es_ex_zip;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        wb_ex;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_final_result;
    logic        ms_res_from_mem;
    logic        ms_csr_re;
    logic [80:0] ms_ex_zip;
    logic        ms_ex;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [4:0] T_B  = 5'b00001;
    localparam logic [4:0] T_H  = 5'b00010;
    localparam logic [4:0] T_W  = 5'b00100;
    localparam logic [4:0] T_BU = 5'b01000;
    localparam logic [4:0] T_HU = 5'b10000;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_pc           (es_pc),
        .es_rf_we        (es_rf_we),
        .es_rf_waddr     (es_rf_waddr),
        .es_alu_result   (es_alu_result),
        .es_res_from_mem (es_res_from_mem),
        .es_ld_inst      (es_ld_inst),
        .es_csr_re       (es_csr_re),
        .es_ex_zip       (es_ex_zip),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .wb_ex           (wb_ex),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_rf_we        (ms_rf_we),
        .ms_rf_waddr     (ms_rf_waddr),
        .ms_final_result (ms_final_result),
        .ms_res_from_mem (ms_res_from_mem),
        .ms_csr_re       (ms_csr_re),
        .ms_ex_zip       (ms_ex_zip),
        .ms_ex           (ms_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen on the
    // falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic mem, input logic [4:0] ld, input logic [80:0] zip);
        es_to_ms_valid  = v;
        es_pc           = pc;
        es_rf_we        = 1'b1;
        es_rf_waddr     = pc[6:2];
        es_alu_result   = alu;
        es_res_from_mem = mem;
        es_ld_inst      = ld;
        es_csr_re       = 1'b0;
        es_ex_zip       = zip;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 81'd0);
        es_rf_we = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        @(negedge clk);
        n_cmp++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b expected 0", ms_to_ws_valid);
        end
        n_cmp++;
        if (ms_allowin !== 1'b1) begin
            n_bad++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin);
        end
        n_cmp++;
        if ({ms_pc, ms_final_result, ms_rf_waddr, ms_rf_we, ms_res_from_mem, ms_csr_re, ms_ex} !== 73'd0) begin
            n_bad++; $display("FAIL reset_outputs: got pc=%h res=%h we=%b expected all 0", ms_pc, ms_final_result, ms_rf_we);
        end
        n_cmp++;
        if (ms_ex_zip !== 81'd0) begin
            n_bad++; $display("FAIL reset_ex_zip: got %h expected 0", ms_ex_zip);
        end
        step();
        resetn = 1'b1;
    endtask

    task automatic test_load_extract();
        logic [31:0] addr [8];
        logic [4:0]  typ  [8];
        logic [31:0] expv [8];
        addr[0] = 32'h1001; typ[0] = T_B;  expv[0] = 32'h00000012;
        addr[1] = 32'h1003; typ[1] = T_B;  expv[1] = 32'hFFFFFF80;
        addr[2] = 32'h1002; typ[2] = T_HU; expv[2] = 32'h000080FF;
        addr[3] = 32'h1002; typ[3] = T_H;  expv[3] = 32'hFFFF80FF;
        addr[4] = 32'h1000; typ[4] = T_W;  expv[4] = 32'h80FF1234;
        addr[5] = 32'h1003; typ[5] = T_BU; expv[5] = 32'h00000080;
        addr[6] = 32'h1002; typ[6] = T_BU; expv[6] = 32'h000000FF;
        addr[7] = 32'h1000; typ[7] = T_H;  expv[7] = 32'h00001234;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1c000000 + 32'(i*4), addr[i], 1'b1, typ[i], 81'd0);
            step();
            idle();
            data_sram_rdata = 32'h80FF1234;
            @(negedge clk);
            n_cmp++;
            if (ms_final_result !== expv[i]) begin
                n_bad++; $display("FAIL load_extract[%0d]: got %h expected %h", i, ms_final_result, expv[i]);
            end
            n_cmp++;
            if ({ms_to_ws_valid, ms_res_from_mem, ms_rf_we} !== 3'b111) begin
                n_bad++; $display("FAIL load_flags[%0d]: got %b expected 111", i, {ms_to_ws_valid, ms_res_from_mem, ms_rf_we});
            end
            n_cmp++;
            if (ms_pc !== 32'h1c000000 + 32'(i*4)) begin
                n_bad++; $display("FAIL load_pc[%0d]: got %h expected %h", i, ms_pc, 32'h1c000000 + 32'(i*4));
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_bad++; $display("FAIL load_drain: got %b expected 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_stall();
        int handoffs;
        drive(1'b1, 32'h1c000100, 32'h1001, 1'b1, T_B, 81'd0);
        step();
        idle();
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h80FF1234;
        @(negedge clk);
        n_cmp++;
        if (ms_final_result !== 32'h00000012) begin
            n_bad++; $display("FAIL stall_first: got %h expected 00000012", ms_final_result);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            data_sram_rdata = 32'hDEADBEEF;
            drive(1'b1, 32'h1c000200, 32'h5555, 1'b0, 5'd0, 81'd0);
            @(negedge clk);
            n_cmp++;
            if (ms_final_result !== 32'h00000012) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got %h expected 00000012", i, ms_final_result);
            end
            n_cmp++;
            if ({ms_to_ws_valid, ms_allowin} !== 2'b10) begin
                n_bad++; $display("FAIL stall_handshake[%0d]: got %b expected 10", i, {ms_to_ws_valid, ms_allowin});
            end
            n_cmp++;
            if (ms_pc !== 32'h1c000100) begin
                n_bad++; $display("FAIL stall_pc[%0d]: got %h expected 1c000100", i, ms_pc);
            end
        end
        step();
        idle();
        ws_allowin = 1'b1;
        handoffs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ms_to_ws_valid && ws_allowin) handoffs++;
            step();
        end
        n_cmp++;
        if (handoffs !== 1) begin
            n_bad++; $display("FAIL stall_handoffs: got %0d expected 1", handoffs);
        end
    endtask

    task automatic test_non_load();
        drive(1'b1, 32'h1c000300, 32'h12345678, 1'b0, 5'd0, 81'd0);
        es_csr_re = 1'b1;
        step();
        idle();
        data_sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++;
        if (ms_final_result !== 32'h12345678) begin
            n_bad++; $display("FAIL nonload_result: got %h expected 12345678", ms_final_result);
        end
        n_cmp++;
        if ({ms_res_from_mem, ms_to_ws_valid, ms_csr_re} !== 3'b011) begin
            n_bad++; $display("FAIL nonload_flags: got %b expected 011", {ms_res_from_mem, ms_to_ws_valid, ms_csr_re});
        end
        step();
    endtask

    task automatic test_exception();
        logic [80:0] zip;
        // Only csr_we set: not an exception.
        zip = 81'd0; zip[80] = 1'b1;
        drive(1'b1, 32'h1c000400, 32'h0, 1'b0, 5'd0, zip);
        step();
        idle();
        @(negedge clk);
        n_cmp++;
        if (ms_ex !== 1'b0 || ms_ex_zip !== zip) begin
            n_bad++; $display("FAIL ex_csr_only: got ex=%b zip=%h expected ex=0 zip=%h", ms_ex, ms_ex_zip, zip);
        end
        // ertn
        zip = 81'd1;
        step();
        drive(1'b1, 32'h1c000404, 32'h0, 1'b0, 5'd0, zip);
        step();
        idle();
        @(negedge clk);
        n_cmp++;
        if (ms_ex !== 1'b1) begin
            n_bad++; $display("FAIL ex_ertn: got %b expected 1", ms_ex);
        end
        // syscall, then flush while a new instruction is offered
        zip = 81'd2;
        step();
        drive(1'b1, 32'h1c000408, 32'h0, 1'b0, 5'd0, zip);
        step();
        drive(1'b1, 32'h1c00040c, 32'h0, 1'b0, 5'd0, 81'd0);
        wb_ex = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ms_ex !== 1'b1) begin
            n_bad++; $display("FAIL ex_syscall: got %b expected 1", ms_ex);
        end
        step();
        wb_ex = 1'b0;
        idle();
        @(negedge clk);
        n_cmp++;
        if ({ms_to_ws_valid, ms_rf_we, ms_ex} !== 3'b000) begin
            n_bad++; $display("FAIL flush: got valid/we/ex=%b expected 000", {ms_to_ws_valid, ms_rf_we, ms_ex});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [4];
        logic [31:0] expv [4];
        rd[0] = 32'h11223344; expv[0] = 32'h11223344;
        rd[1] = 32'hA5A5C3C3; expv[1] = 32'hFFFFFFA5;
        rd[2] = 32'h7F00FE01; expv[2] = 32'h00007F00;
        rd[3] = 32'h01020384; expv[3] = 32'hFFFFFF84;
        drive(1'b1, 32'h1c000500, 32'h2000, 1'b1, T_W, 81'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            data_sram_rdata = rd[i];
            case (i)
                0: drive(1'b1, 32'h1c000504, 32'h2003, 1'b1, T_B,  81'd0);
                1: drive(1'b1, 32'h1c000508, 32'h2002, 1'b1, T_HU, 81'd0);
                2: drive(1'b1, 32'h1c00050c, 32'h2000, 1'b1, T_B,  81'd0);
                default: idle();
            endcase
            @(negedge clk);
            n_cmp++;
            if (ms_final_result !== expv[i] || ms_to_ws_valid !== 1'b1) begin
                n_bad++; $display("FAIL b2b[%0d]: got %h valid=%b expected %h valid=1", i, ms_final_result, ms_to_ws_valid, expv[i]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 32'h1c000600, 32'h3000, 1'b1, T_W, 81'd0);
        step();
        idle();
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h0BADF00D;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ms_to_ws_valid, ms_allowin} !== 2'b01 || ms_final_result !== 32'd0) begin
            n_bad++; $display("FAIL reset_stall: got valid/allowin=%b res=%h expected 01 / 00000000", {ms_to_ws_valid, ms_allowin}, ms_final_result);
        end
        ws_allowin = 1'b1;
        step();
    endtask

    initial begin
        resetn = 1'b0;
        ws_allowin = 1'b1;
        wb_ex = 1'b0;
        data_sram_rdata = 32'd0;
        idle();
        test_reset();
        test_load_extract();
        test_stall();
        test_non_load();
        test_exception();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
